disp_vram_rdslave: RTL and testbench

//  AXI4 read-channel responder that serves frame-buffer data to the display VRAM read master.

---
 rtl/disp_axi_pkg.sv | 12 +
 rtl/disp_vram_mem.sv | 26 ++
 rtl/disp_vram_rdslave.sv | 137 +++++++++++++
 tb/tb_disp_vram_rdslave.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_axi_pkg.sv
// Shared AXI read-channel constants, FSM encoding and beat-count type for the display VRAM path.
package disp_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  typedef logic [8:0] beat_cnt_t;

endpackage

// File: rtl/disp_vram_mem.sv
// 1R1W synchronous VRAM array; registered read with read-first behaviour on a same-word collision.
module disp_vram_mem #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/disp_vram_rdslave.sv
// AXI4 INCR read responder serving display VRAM words through a 2-entry skid FIFO.
// Define DISP_VRAM_RANGECHK_EN to flag beats past the end of VRAM with SLVERR instead of wrapping.
module disp_vram_rdslave
  import disp_axi_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          ACLK,
  input  logic          ARST,
  input  logic [31:0]   ARADDR,
  input  logic [7:0]    ARLEN,
  input  logic          ARVALID,
  output logic          ARREADY,
  output logic [DW-1:0] RDATA,
  output logic [1:0]    RRESP,
  output logic          RLAST,
  output logic          RVALID,
  input  logic          RREADY,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] WDATA
);

`ifdef DISP_VRAM_RANGECHK_EN
  localparam int unsigned CW = 32;
`else
  localparam int unsigned CW = AW;
`endif

  logic [0:0]    r_state;
  logic [CW-1:0] r_word;
  beat_cnt_t     r_left;
  logic          r_infl, r_infl_last, r_infl_err;
  logic [DW-1:0] r_fd [2];
  logic [1:0]    r_fr [2];
  logic          r_fl [2];
  logic          r_wp, r_rp;
  logic [1:0]    r_cnt;

  logic          w_ar_hs, w_pop, w_issue, w_rd_last, w_rd_err;
  logic [CW-1:0] w_ar_word, w_rd_word;
  logic [DW-1:0] w_ram_q;
  logic          w_unused_addr;

`ifdef DISP_VRAM_RANGECHK_EN
  assign w_ar_word     = {2'b00, ARADDR[31:2]};
  assign w_unused_addr = ^ARADDR[1:0];
`else
  assign w_ar_word     = ARADDR[AW+1:2];
  assign w_unused_addr = ^{ARADDR[31:AW+2], ARADDR[1:0]};
`endif

  always_comb begin
    w_ar_hs = ARVALID && (r_state == S_IDLE);
    w_pop   = (r_cnt != 2'd0) && RREADY;
    // The first read issues in the AR accept cycle, so data lands in the FIFO one cycle later.
    if (r_state == S_IDLE) begin
      w_rd_word = w_ar_word;
      w_rd_last = (ARLEN == 8'd0);
      w_issue   = w_ar_hs;
    end else begin
      w_rd_word = r_word;
      w_rd_last = (r_left == beat_cnt_t'(1));
      // A slot freed by this cycle's pop counts as free, keeping one beat per cycle.
      w_issue   = (r_left != '0) &&
                  (({1'b0, r_cnt} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop}));
    end
`ifdef DISP_VRAM_RANGECHK_EN
    w_rd_err = (w_rd_word >= CW'(DEPTH));
`else
    w_rd_err = 1'b0;
`endif
  end

  disp_vram_mem #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .i_clk  (ACLK),
    .i_we   (WE),
    .i_waddr(WADDR),
    .i_wdata(WDATA),
    .i_re   (w_issue),
    .i_raddr(w_rd_word[AW-1:0]),
    .o_rdata(w_ram_q)
  );

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_left      <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_infl_err  <= 1'b0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fd[i] <= '0;
        r_fr[i] <= RESP_OKAY;
        r_fl[i] <= 1'b0;
      end
    end else begin
      if (w_ar_hs)                  r_state <= S_BURST;
      else if (w_pop && r_fl[r_rp]) r_state <= S_IDLE;

      if (w_ar_hs)      r_left <= beat_cnt_t'(ARLEN);
      else if (w_issue) r_left <= r_left - beat_cnt_t'(1);

      if (w_issue) r_word <= w_rd_word + CW'(1);

      r_infl      <= w_issue;
      r_infl_last <= w_rd_last;
      r_infl_err  <= w_rd_err;

      if (r_infl) begin
        r_fd[r_wp] <= r_infl_err ? '0 : w_ram_q;
        r_fr[r_wp] <= r_infl_err ? RESP_SLVERR : RESP_OKAY;
        r_fl[r_wp] <= r_infl_last;
        r_wp       <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
    end
  end

  assign ARREADY = (r_state == S_IDLE);
  assign RVALID  = (r_cnt != 2'd0);
  assign RDATA   = r_fd[r_rp];
  assign RRESP   = r_fr[r_rp];
  assign RLAST   = r_fl[r_rp] && RVALID;

endmodule

// File: tb/tb_disp_vram_rdslave.sv
// Scoreboard bench for disp_vram_rdslave: stimulus pushes expected beats, a monitor pops on R handshakes.
module tb_disp_vram_rdslave;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16384;
  localparam int unsigned AW    = 14;

  logic          ACLK, ARST;
  logic [31:0]   ARADDR;
  logic [7:0]    ARLEN;
  logic          ARVALID, ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST, RVALID, RREADY;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WDATA;

  disp_vram_rdslave #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .ACLK   (ACLK),
    .ARST   (ARST),
    .ARADDR (ARADDR),
    .ARLEN  (ARLEN),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RLAST  (RLAST),
    .RVALID (RVALID),
    .RREADY (RREADY),
    .WE     (WE),
    .WADDR  (WADDR),
    .WDATA  (WDATA)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [31:0] tb_mem [DEPTH];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          beats_rx = 0;
  int          last_hs_cyc = -1;
  int          acc_cyc = 0;
  int          exp_first_cyc = 0;
  bit          first_pending = 0;
  bit          bp_en = 0;
  logic [5:0]  bp_pat = 6'b101001;
  bit          hold_v = 0;
  logic [31:0] hold_d;
  logic [1:0]  hold_r;
  logic        hold_l;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected the run to finish");
    $fatal(1);
  end

  // RREADY pattern 1,0,0,1,0,1 while backpressure is enabled, otherwise always ready.
  initial begin
    int idx = 0;
    RREADY = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      if (bp_en) begin
        RREADY = bp_pat[idx];
        idx = (idx + 1) % 6;
      end else begin
        RREADY = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (!ARST) begin
      if (hold_v) begin
        check("stall_valid", {31'd0, RVALID}, 32'd1);
        check("stall_data", RDATA, hold_d);
        check("stall_resp", {30'd0, RRESP}, {30'd0, hold_r});
        check("stall_last", {31'd0, RLAST}, {31'd0, hold_l});
      end
      if (RVALID && first_pending) begin
        check("first_beat_latency", cyc, exp_first_cyc);
        first_pending = 0;
      end
      if (RVALID && RREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h with no beat expected", RDATA);
        end else begin
          mon_e = exp_q.pop_front();
          check("rdata", RDATA, mon_e.data);
          check("rresp", {30'd0, RRESP}, {30'd0, mon_e.resp});
          check("rlast", {31'd0, RLAST}, {31'd0, mon_e.last});
        end
        beats_rx++;
        if (RLAST) last_hs_cyc = cyc;
      end
      hold_v = RVALID && !RREADY;
      hold_d = RDATA;
      hold_r = RRESP;
      hold_l = RLAST;
    end else begin
      hold_v = 0;
    end
  end

  task automatic mem_write(input int a, input logic [31:0] d);
    WE = 1'b1;
    WADDR = AW'(a);
    WDATA = d;
    @(posedge ACLK);
    #1;
    WE = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic ar_issue(input logic [31:0] a, input logic [7:0] l, input bit keep);
    int n = 0;
    int w;
    beat_t e;
    ARADDR = a;
    ARLEN = l;
    ARVALID = 1'b1;
    do begin
      @(negedge ACLK);
      n++;
    end while (!ARREADY && n < 300);
    checks++;
    if (!ARREADY) begin
      errors++;
      $display("FAIL ar_accept: ARREADY still 0 after %0d cycles, expected 1", n);
      ARVALID = 1'b0;
      return;
    end
    acc_cyc = cyc;
    exp_first_cyc = cyc + 2;
    first_pending = 1;
    for (int k = 0; k <= int'(l); k++) begin
      w = int'(a[31:2]) + k;
      e.last = (k == int'(l));
`ifdef DISP_VRAM_RANGECHK_EN
      if (w >= int'(DEPTH)) begin
        e.data = 32'd0;
        e.resp = 2'b10;
      end else begin
        e.data = tb_mem[w];
        e.resp = 2'b00;
      end
`else
      e.data = tb_mem[w % int'(DEPTH)];
      e.resp = 2'b00;
`endif
      exp_q.push_back(e);
    end
    @(posedge ACLK);
    #1;
    if (!keep) ARVALID = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || RVALID) && n < 400) begin
      @(negedge ACLK);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int b0;
    int n;
    ARST = 1'b1;
    ARVALID = 1'b0;
    ARADDR = '0;
    ARLEN = '0;
    WE = 1'b0;
    WADDR = '0;
    WDATA = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_arready", {31'd0, ARREADY}, 32'd1);
    check("reset_rvalid", {31'd0, RVALID}, 32'd0);
    check("reset_rlast", {31'd0, RLAST}, 32'd0);
    check("reset_rdata", RDATA, 32'd0);
    check("reset_rresp", {30'd0, RRESP}, 32'd0);
    @(posedge ACLK);
    #1;
    ARST = 1'b0;

    for (int i = 0; i < 128; i++) mem_write(i, 32'(i));
    for (int i = DEPTH - 4; i < DEPTH; i++) mem_write(i, 32'(i));

    // Single burst: words 0x40..0x47.
    b0 = beats_rx;
    ar_issue(32'h100, 8'd7, 1'b0);
    drain("single_drain");
    check("single_beats", beats_rx - b0, 32'd8);

    // Same burst under RREADY backpressure.
    bp_en = 1;
    b0 = beats_rx;
    ar_issue(32'h100, 8'd7, 1'b0);
    drain("bp_drain");
    bp_en = 0;
    check("bp_beats", beats_rx - b0, 32'd8);

    // Back-to-back with ARVALID held high.
    b0 = beats_rx;
    ar_issue(32'h0, 8'd3, 1'b1);
    @(negedge ACLK);
    check("b2b_arready_busy", {31'd0, ARREADY}, 32'd0);
    ar_issue(32'h40, 8'd3, 1'b0);
    check("b2b_accept_gap", acc_cyc, last_hs_cyc + 1);
    drain("b2b_drain");
    check("b2b_beats", beats_rx - b0, 32'd8);

    // Burst crossing the end of VRAM.
    b0 = beats_rx;
    ar_issue(32'((DEPTH - 2) * 4), 8'd3, 1'b0);
    drain("range_drain");
    check("range_beats", beats_rx - b0, 32'd4);

    // Reset after beat 2 of an 8-beat burst.
    b0 = beats_rx;
    ar_issue(32'h0, 8'd7, 1'b0);
    n = 0;
    while (beats_rx - b0 < 2 && n < 100) begin
      @(posedge ACLK);
      n++;
    end
    #1;
    ARST = 1'b1;
    exp_q.delete();
    first_pending = 0;
    @(posedge ACLK);
    #1;
    ARST = 1'b0;
    @(negedge ACLK);
    check("midrst_rvalid", {31'd0, RVALID}, 32'd0);
    check("midrst_arready", {31'd0, ARREADY}, 32'd1);
    check("midrst_rlast", {31'd0, RLAST}, 32'd0);
    check("midrst_rdata", RDATA, 32'd0);
    @(posedge ACLK);
    #1;
    ar_issue(32'h20, 8'd3, 1'b0);
    drain("midrst_new_burst");

    // Write and read of word 5 on the same edge: old data first, new data on re-read.
    WE = 1'b1;
    WADDR = AW'(5);
    WDATA = 32'hDEAD_0005;
    ar_issue(32'h14, 8'd0, 1'b0);
    WE = 1'b0;
    tb_mem[5] = 32'hDEAD_0005;
    drain("coll_old_drain");
    ar_issue(32'h14, 8'd0, 1'b0);
    drain("coll_new_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
